// File: rtl/rr_serial_arbiter_pkg.sv
// Shared types and constants for the round-robin serial channel arbiter.
// Holds the FSM state encoding, default parameter values and width helpers.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_BURST   = 8;
    localparam int DEF_GAP_CYC = 1;
    localparam int GAP_W       = 4;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Counters still need one bit when the range collapses to a single value.
    function automatic int clog2_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rr_serial_arbiter_pick.sv
// Circular priority picker: first set request at or after ptr_i, wrapping at NREQ.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int ID_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    logic hit_s;

    // ptr_i is always below NREQ, so one conditional subtraction wraps any offset.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NREQ) ? (sum - NREQ) : sum;
        return sum[ID_W-1:0];
    endfunction

    // Scan offsets 0..NREQ-1 from the pointer and keep the first hit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        hit_s   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            hit_s   = ~found_o & req_i[wrap_add(ptr_i, off)];
            idx_o   = hit_s ? wrap_add(ptr_i, off) : idx_o;
            found_o = found_o | hit_s;
        end
    end

endmodule

// File: rtl/rr_serial_arbiter.sv
// Round-robin owner of a shared single-bit serial channel: grant, burst of up to
// BURST bits, optional GAP turnaround, then re-arbitrate from the next index.
module rr_serial_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int BURST   = DEF_BURST,
    parameter  int GAP_CYC = DEF_GAP_CYC,
    localparam int ID_W    = clog2(NREQ),
    localparam int CNT_W   = clog2_min1(BURST)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);
    localparam bit               HAS_GAP  = (GAP_CYC > 0);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic             pick_found_s;
    logic [ID_W-1:0]  pick_idx_s;
    logic             owner_req_s;
    logic [ID_W-1:0]  ptr_next_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Owner's live request and the pointer slot just after the owner.
    always_comb begin
        owner_req_s = req[gnt_id_q];
        ptr_next_s  = (gnt_id_q == ID_LAST) ? '0 : (gnt_id_q + ID_W'(1));
    end

    // Next-state logic; other requesters are never looked at outside IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d  = GRANT;
                    gnt_d    = NREQ'(1) << pick_idx_s;
                    gnt_id_d = pick_idx_s;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            GRANT: begin
                // A dropped request ends the grant even on what would be the last bit.
                if (!owner_req_s || (cnt_q == CNT_LAST)) begin
                    state_d  = HAS_GAP ? GAP : IDLE;
                    ptr_d    = ptr_next_s;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    cnt_d    = '0;
                    gap_d    = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                gap_d    = '0;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // State, counter, pointer and grant registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = (state_q != IDLE);
    assign ser_valid = (state_q == GRANT) & owner_req_s;
    assign ser_out   = din[gnt_id_q] & ser_valid;

endmodule

// File: tb/tb_rr_serial_arbiter.sv
// Self-checking bench: a default-parameter arbiter plus a NREQ=3/BURST=1/GAP_CYC=0
// corner instance, both compared cycle by cycle against a slot-level reference model.
module tb_rr_serial_arbiter;

    localparam int N0 = 4, B0 = 8, G0 = 1;
    localparam int N1 = 3, B1 = 1, G1 = 0;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [3:0] req0 = 4'd0, din0 = 4'd0, gnt0;
    logic [1:0] gnt_id0;
    logic       ser_out0, ser_valid0, busy0;
    logic [2:0] req1 = 3'd0, din1 = 3'd0, gnt1;
    logic [1:0] gnt_id1;
    logic       ser_out1, ser_valid1, busy1;

    rr_serial_arbiter #(.NREQ(N0), .BURST(B0), .GAP_CYC(G0)) u_dut0 (
        .CLK(CLK), .RST(RST), .req(req0), .din(din0), .gnt(gnt0), .gnt_id(gnt_id0),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .busy(busy0)
    );

    rr_serial_arbiter #(.NREQ(N1), .BURST(B1), .GAP_CYC(G1)) u_dut1 (
        .CLK(CLK), .RST(RST), .req(req1), .din(din1), .gnt(gnt1), .gnt_id(gnt_id1),
        .ser_out(ser_out1), .ser_valid(ser_valid1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;

    // Sampled vectors {gnt[3:0], gnt_id[1:0], ser_valid, ser_out, busy}.
    logic [8:0] act0, exp0, act1, exp1;

    // Reference model: current owner (-1 = none), bits already sent, remaining turnaround
    // cycles and the index the next search starts from.
    int m_owner[2], m_bits[2], m_cool[2], m_ptr[2];

    function automatic int pn(input int m); return (m == 0) ? N0 : N1; endfunction
    function automatic int pb(input int m); return (m == 0) ? B0 : B1; endfunction
    function automatic int pg(input int m); return (m == 0) ? G0 : G1; endfunction

    task automatic model_reset(input int m);
        m_owner[m] = -1; m_bits[m] = 0; m_cool[m] = 0; m_ptr[m] = 0;
    endtask

    function automatic logic [8:0] model_vec(input int m, input logic [3:0] r, input logic [3:0] d);
        logic [3:0] g;
        logic [1:0] id;
        logic v, o, b;
        g = 4'd0; id = 2'd0; v = 1'b0; o = 1'b0;
        if (m_owner[m] >= 0) begin
            g[m_owner[m]] = 1'b1;
            id = 2'(m_owner[m]);
            v  = r[m_owner[m]];
            o  = v & d[m_owner[m]];
        end
        b = (m_owner[m] >= 0) || (m_cool[m] > 0);
        return {g, id, v, o, b};
    endfunction

    task automatic model_step(input int m, input logic [3:0] r);
        int n, found, idx;
        n = pn(m);
        if (m_owner[m] >= 0) begin
            if (!r[m_owner[m]] || (m_bits[m] + 1 == pb(m))) begin
                m_ptr[m] = (m_owner[m] + 1) % n;
                m_owner[m] = -1;
                m_cool[m] = pg(m);
            end else begin
                m_bits[m] = m_bits[m] + 1;
            end
        end else if (m_cool[m] > 0) begin
            m_cool[m] = m_cool[m] - 1;
        end else begin
            found = 0;
            for (int k = 0; k < n; k++) begin
                idx = (m_ptr[m] + k) % n;
                if (found == 0 && r[idx]) begin
                    found = 1; m_owner[m] = idx; m_bits[m] = 0;
                end
            end
        end
    endtask

    // Sample both DUTs mid-cycle, then let the models see the same clock edge.
    task automatic advance();
        @(negedge CLK);
        act0 = {gnt0, gnt_id0, ser_valid0, ser_out0, busy0};
        exp0 = model_vec(0, req0, din0);
        act1 = {1'b0, gnt1, gnt_id1, ser_valid1, ser_out1, busy1};
        exp1 = model_vec(1, {1'b0, req1}, {1'b0, din1});
        @(posedge CLK);
        model_step(0, req0);
        model_step(1, {1'b0, req1});
        #1;
    endtask

    task automatic do_reset();
        req0 = 4'd0; din0 = 4'd0; req1 = 3'd0; din1 = 3'd0;
        @(negedge CLK);
        RST = 1'b0;
        model_reset(0); model_reset(1);
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic test_reset();
        model_reset(0); model_reset(1);
        #1 RST = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt_id0, ser_valid0, ser_out0, busy0} !== 9'd0) begin
            failures++; $display("FAIL reset_dut0 got=%b want=%b", {gnt0, gnt_id0, ser_valid0, ser_out0, busy0}, 9'd0);
        end
        checks++;
        if ({gnt1, gnt_id1, ser_valid1, ser_out1, busy1} !== 8'd0) begin
            failures++; $display("FAIL reset_dut1 got=%b want=%b", {gnt1, gnt_id1, ser_valid1, ser_out1, busy1}, 8'd0);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        advance();
        checks++;
        if (act0 !== exp0) begin failures++; $display("FAIL reset_idle got=%b want=%b", act0, exp0); end
    endtask

    task automatic test_single_burst();
        logic [3:0] g_tr[24];
        logic v_tr[24], b_tr[24];
        int nvalid;
        do_reset();
        req0 = 4'b0010;
        for (int k = 0; k < 24; k++) begin
            din0 = 4'($urandom);
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL single_model k=%0d got=%b want=%b", k, act0, exp0); end
            g_tr[k] = act0[8:5]; v_tr[k] = act0[2]; b_tr[k] = act0[0];
        end
        nvalid = 0;
        for (int k = 1; k <= 8; k++) nvalid += int'(v_tr[k]);
        checks++;
        if (g_tr[1] !== 4'b0010) begin failures++; $display("FAIL single_first_gnt got=%b want=0010", g_tr[1]); end
        checks++;
        if (nvalid != 8) begin failures++; $display("FAIL single_valid_count got=%0d want=8", nvalid); end
        checks++;
        if ({g_tr[9], b_tr[9]} !== 5'b0000_1) begin failures++; $display("FAIL single_gap got=%b want=00001", {g_tr[9], b_tr[9]}); end
        checks++;
        if ({g_tr[10], b_tr[10]} !== 5'b0000_0) begin failures++; $display("FAIL single_idle got=%b want=00000", {g_tr[10], b_tr[10]}); end
        checks++;
        if (g_tr[11] !== 4'b0010) begin failures++; $display("FAIL single_regrant got=%b want=0010", g_tr[11]); end
    endtask

    task automatic test_round_robin();
        int start_k[$], start_id[$], vcnt[$];
        logic [3:0] prev_g;
        do_reset();
        req0 = 4'b1111;
        prev_g = 4'd0;
        for (int k = 0; k < 60; k++) begin
            din0 = 4'($urandom);
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL rr_model k=%0d got=%b want=%b", k, act0, exp0); end
            if (act0[8:5] != 4'd0 && prev_g == 4'd0) begin
                start_k.push_back(k); start_id.push_back(int'(act0[4:3])); vcnt.push_back(0);
            end
            if (act0[2] && vcnt.size() > 0) vcnt[vcnt.size()-1] = vcnt[vcnt.size()-1] + 1;
            prev_g = act0[8:5];
        end
        checks++;
        if (start_id.size() < 5) begin
            failures++; $display("FAIL rr_grant_count got=%0d want>=5", start_id.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (start_id[i] != i % 4) begin failures++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", i, start_id[i], i % 4); end
                checks++;
                if (start_k[i] != 1 + 10 * i) begin failures++; $display("FAIL rr_slot_time slot=%0d got=%0d want=%0d", i, start_k[i], 1 + 10 * i); end
                checks++;
                if (vcnt[i] != 8) begin failures++; $display("FAIL rr_bits slot=%0d got=%0d want=8", i, vcnt[i]); end
            end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] g_tr[10];
        logic [1:0] id_tr[10];
        logic v_tr[10];
        int nvalid;
        do_reset();
        req0 = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) req0 = 4'b0001;
            if (k == 5) req0 = 4'b0101;
            din0 = 4'($urandom);
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL early_model k=%0d got=%b want=%b", k, act0, exp0); end
            g_tr[k] = act0[8:5]; id_tr[k] = act0[4:3]; v_tr[k] = act0[2];
        end
        nvalid = 0;
        for (int k = 1; k <= 4; k++) nvalid += int'(v_tr[k]);
        checks++;
        if (nvalid != 3) begin failures++; $display("FAIL early_bits got=%0d want=3", nvalid); end
        checks++;
        if ({g_tr[4], v_tr[4]} !== 5'b0100_0) begin failures++; $display("FAIL early_release_cycle got=%b want=01000", {g_tr[4], v_tr[4]}); end
        checks++;
        if (g_tr[5] !== 4'b0000) begin failures++; $display("FAIL early_gnt_drop got=%b want=0000", g_tr[5]); end
        checks++;
        if ({g_tr[7], id_tr[7]} !== 6'b0001_00) begin failures++; $display("FAIL early_next_owner got=%b want=000100", {g_tr[7], id_tr[7]}); end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] g1;
        logic [1:0] id1;
        do_reset();
        req0 = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            din0 = 4'($urandom);
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL rstmid_model k=%0d got=%b want=%b", k, act0, exp0); end
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({gnt0, ser_valid0, busy0} !== 6'b1000_1_1) begin
            failures++; $display("FAIL rstmid_active got=%b want=100011", {gnt0, ser_valid0, busy0});
        end
        RST = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        checks++;
        if ({gnt0, gnt_id0, ser_valid0, ser_out0, busy0} !== 9'd0) begin
            failures++; $display("FAIL rstmid_async got=%b want=%b", {gnt0, gnt_id0, ser_valid0, ser_out0, busy0}, 9'd0);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        req0 = 4'b1001;
        g1 = 4'd0; id1 = 2'd0;
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL rstmid_after k=%0d got=%b want=%b", k, act0, exp0); end
            if (k == 1) begin g1 = act0[8:5]; id1 = act0[4:3]; end
        end
        checks++;
        if ({g1, id1} !== 6'b0001_00) begin failures++; $display("FAIL rstmid_regrant got=%b want=000100", {g1, id1}); end
    endtask

    task automatic test_corner();
        int ids[$];
        logic [2:0] g;
        do_reset();
        req1 = 3'b111;
        for (int k = 0; k < 12; k++) begin
            din1 = 3'($urandom);
            advance();
            checks++;
            if (act1 !== exp1) begin failures++; $display("FAIL corner_model k=%0d got=%b want=%b", k, act1, exp1); end
            g = act1[7:5];
            if (g != 3'd0) begin
                ids.push_back(int'(act1[4:3]));
                checks++;
                if (act1[2] !== 1'b1) begin failures++; $display("FAIL corner_one_bit k=%0d got=%b want=1", k, act1[2]); end
            end
            checks++;
            if (act1[4:3] > 2'd2) begin failures++; $display("FAIL corner_id_range k=%0d got=%0d want<=2", k, act1[4:3]); end
            checks++;
            if (act1[0] && g == 3'd0) begin failures++; $display("FAIL corner_gap_seen k=%0d got=busy_no_gnt want=none", k); end
        end
        checks++;
        if (ids.size() < 4) begin
            failures++; $display("FAIL corner_grant_count got=%0d want>=4", ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ids[i] != i % 3) begin failures++; $display("FAIL corner_order slot=%0d got=%0d want=%0d", i, ids[i], i % 3); end
            end
        end
    endtask

    task automatic test_random_sweep();
        int pend[2][4], off[2][4], wt[2][4], lim[2];
        bit trk[2][4];
        logic [8:0] a;
        logic [3:0] g, rv[2];
        do_reset();
        lim[0] = (N0 - 1) * (B0 + G0 + 1) + 1;
        lim[1] = (N1 - 1) * (B1 + G1 + 1) + 1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) begin
                pend[m][i] = 0; off[m][i] = 0; wt[m][i] = 0; trk[m][i] = 1'b0;
            end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                rv[m] = 4'd0;
                for (int i = 0; i < pn(m); i++) rv[m][i] = (pend[m][i] > 0);
            end
            req0 = rv[0]; req1 = rv[1][2:0];
            din0 = 4'($urandom); din1 = 3'($urandom);
            advance();
            checks++;
            if (act0 !== exp0) begin failures++; $display("FAIL sweep_model0 cyc=%0d got=%b want=%b", cyc, act0, exp0); end
            checks++;
            if (act1 !== exp1) begin failures++; $display("FAIL sweep_model1 cyc=%0d got=%b want=%b", cyc, act1, exp1); end
            for (int m = 0; m < 2; m++) begin
                a = (m == 0) ? act0 : act1;
                g = a[8:5];
                checks++;
                if (!$onehot0(g)) begin failures++; $display("FAIL inv_onehot dut=%0d cyc=%0d got=%b want=onehot0", m, cyc, g); end
                checks++;
                if (a[2] && g == 4'd0) begin failures++; $display("FAIL inv_valid_gnt dut=%0d cyc=%0d got=%b want=nonzero", m, cyc, g); end
                checks++;
                if (!a[0] && g != 4'd0) begin failures++; $display("FAIL inv_idle_gnt dut=%0d cyc=%0d got=%b want=0", m, cyc, g); end
                for (int i = 0; i < pn(m); i++) begin
                    if (trk[m][i]) begin
                        if (g[i]) begin
                            checks++;
                            if (wt[m][i] > lim[m]) begin
                                failures++; $display("FAIL wait_bound dut=%0d req=%0d got=%0d want<=%0d", m, i, wt[m][i], lim[m]);
                            end
                            trk[m][i] = 1'b0;
                        end else begin
                            wt[m][i] = wt[m][i] + 1;
                        end
                    end
                    if (a[2] && int'(a[4:3]) == i && pend[m][i] > 0) begin
                        pend[m][i] = pend[m][i] - 1;
                        if (pend[m][i] == 0) off[m][i] = $urandom_range(6, 2);
                    end else if (pend[m][i] == 0) begin
                        if (off[m][i] > 0) begin
                            off[m][i] = off[m][i] - 1;
                        end else if ($urandom_range(3, 0) == 0) begin
                            pend[m][i] = $urandom_range(12, 1);
                            trk[m][i] = 1'b1;
                            wt[m][i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_early_release();
        test_reset_mid_burst();
        test_corner();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_serial_arbiter.md
Name: rr_serial_arbiter

Overview:
- Round-robin arbiter that shares one single-bit serial channel between NREQ requesters.
- The channel feeds the team's serial-input FSM blocks (In1-style inputs).
- A granted requester owns the channel for a burst of up to BURST bits, then releases it. A GAP_CYC turnaround follows before the next grant.
- Sits between the bit-stream sources and the shared detector FSM. It sequences which source drives the FSM input.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- BURST, 8, maximum valid bits per grant; legal minimum 1.
- GAP_CYC, 1, idle turnaround cycles after each grant; legal range 0..15.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- RST, input, 1, reset; asynchronous, active-low.
- req, input, NREQ, per-requester request level; held high while the requester has bits to send.
- din, input, NREQ, per-requester serial data bit.
- gnt, output, NREQ, one-hot grant; all zero when no owner.
- gnt_id, output, clog2(NREQ), index of the current owner; 0 when no owner.
- ser_out, output, 1, shared serial bit to the downstream FSM.
- ser_valid, output, 1, ser_out carries a valid bit this cycle.
- busy, output, 1, arbiter is in GRANT or GAP.

Behaviour:
- Reset (async, RST=0):
  - gnt=0, gnt_id=0, busy=0, ser_valid=0, ser_out=0.
  - state=IDLE, burst counter=0, round-robin pointer ptr=0.
  - Asserting RST mid-burst aborts the burst immediately with no completion cycle.
  - Deassertion takes effect on the first CLK edge with RST=1.
- States: IDLE, GRANT, GAP. The state encoding is 2-bit.
- IDLE:
  - Outputs: gnt=0, busy=0.
  - If any req bit is set, select the first set index searching circularly from ptr upward.
  - Next edge: gnt[sel]=1, gnt_id=sel, cnt=0, state=GRANT.
  - Latency: req seen in IDLE at edge t produces gnt at t+1.
- GRANT:
  - ser_valid = req[gnt_id], combinational.
  - ser_out = din[gnt_id] & ser_valid, combinational.
  - Each cycle with req[gnt_id]=1, cnt increments.
  - The grant ends on the edge where either:
    - cnt==BURST-1 and req[gnt_id]=1, after BURST valid bits; or
    - req[gnt_id]=0, an early release in which that cycle carries no valid bit.
  - On grant end:
    - ptr = (gnt_id+1) mod NREQ.
    - gnt=0, gnt_id=0.
    - state=GAP with gap counter=0 if GAP_CYC>0; otherwise state=IDLE.
  - Requests from other indices are ignored during GRANT. There is no preemption.
- GAP:
  - gnt=0, ser_valid=0, busy=1.
  - Exit to IDLE after GAP_CYC cycles.
  - Requests are not sampled in GAP.
- Worst-case wait for a continuously requesting source: (NREQ-1)·(BURST+GAP_CYC+1) cycles. No starvation.
- Counters and widths:
  - cnt is clog2(BURST) bits, minimum 1 bit; the gap counter is 4 bits.
  - ptr increment wraps at NREQ, including non-power-of-2 values. There is no out-of-range index.
- Simultaneous events:
  - A requester that drops req on its final burst cycle counts as early release; ptr still advances.
  - A requester re-raising req during GAP gets priority only per ptr.
  - The owner's own re-request is serviced last among active requesters.
- Invariants (assert in the bench):
  - gnt is onehot0.
  - ser_valid implies gnt≠0.
  - busy=0 implies gnt=0.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum (IDLE=2'b00, GRANT=2'b01, GAP=2'b10);
  - the default parameter values;
  - a clog2 helper constant function.
- One natural sub-module, rr_pick: combinational circular priority picker.
  - Inputs: req vector and ptr.
  - Outputs: found and index.
- The top block holds the FSM, counters, pointer and output mux.

Test Plan:
- Single requester, burst 8: reset, then req=4'b0010 held, din toggling.
  - gnt=4'b0010 one cycle after req; 8 ser_valid cycles with ser_out matching din[1].
  - Then 1 GAP cycle, and gnt reasserts to index 1.
- Round-robin fairness: req=4'b1111 held for 60 cycles.
  - Grant order 0,1,2,3,0 with 8 valid bits each.
  - 10 cycles per slot (8 GRANT + 1 GAP + 1 IDLE).
- Early release: req[2] high, then dropped after 3 valid bits.
  - gnt drops on the next edge; ser_valid low in the release cycle; ptr=3.
  - With req=4'b0101 pending, the next grant goes to index 0, not 2.
- Reset mid-burst: RST=0 asynchronously during the 4th bit of a burst to index 3.
  - gnt, ser_valid and busy go to 0 without a clock edge.
  - After release, req=4'b1001 grants index 0 (ptr=0).
- Parameter corners: NREQ=3, BURST=1, GAP_CYC=0, req=3'b111.
  - Grants cycle 0,1,2,0; one valid bit each; no GAP state visited.
  - No out-of-range gnt_id.
- Invariant sweep: 10k cycles of random req/din.
  - onehot0(gnt) holds throughout.
  - ser_valid→gnt≠0 holds throughout.
  - No requester waits more than (NREQ-1)·(BURST+GAP_CYC+1)+1 cycles from req high to grant.
